// File: rtl/lifo_reverse_ctrl.sv
// Stream-to-stack controller: fills an external push/pop stack with one framed block,
// then drains it so each block leaves in reverse order with m_last on its final word.
module lifo_reverse_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              lifo_w_en,
    output logic              lifo_r_en,
    output logic [DATA_W-1:0] lifo_data_in,
    input  logic [DATA_W-1:0] lifo_data_out,
    input  logic              lifo_full,
    input  logic              lifo_empty,
    output logic              trunc,
    output logic              busy
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              trunc_q, trunc_d;
    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;

    // Internal count decides fullness; the stack's own flags only gate as a backstop.
    assign s_ready      = (state_q == FILL) && (cnt_q < DEPTH_C) && !lifo_full;
    assign accept       = s_valid && s_ready;
    assign cnt_inc      = cnt_q + 1'b1;
    assign lifo_w_en    = accept;
    assign lifo_data_in = s_data;
    assign lifo_r_en    = (state_q == POP) && !lifo_empty;

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;
    assign trunc   = trunc_q;
    assign busy    = (state_q != FILL) || (cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        trunc_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (s_last || (cnt_inc == DEPTH_C)) begin
                        state_d = POP;
                        trunc_d = !s_last;
                    end
                end
            end
            POP: begin
                // Count says data remains but the stack disagrees: resynchronise empty.
                if (lifo_empty) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                m_data_d  = lifo_data_out;
                m_last_d  = (cnt_q == '0);
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d = 1'b0;
                        state_d  = FILL;
                    end else begin
                        state_d = POP;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            trunc_q   <= trunc_d;
        end
    end

endmodule

// File: tb/tb_lifo_reverse_ctrl.sv
// Bench for lifo_reverse_ctrl: attaches a behavioural 32x32 stack, drives directed and random
// blocks, and compares the output stream with per-block reversed queues.
module tb_lifo_reverse_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              lifo_w_en;
    logic              lifo_r_en;
    logic [DATA_W-1:0] lifo_data_in;
    logic [DATA_W-1:0] lifo_data_out;
    logic              lifo_full;
    logic              lifo_empty;
    logic              trunc;
    logic              busy;

    always #5 clk = ~clk;

    lifo_reverse_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .lifo_w_en     (lifo_w_en),
        .lifo_r_en     (lifo_r_en),
        .lifo_data_in  (lifo_data_in),
        .lifo_data_out (lifo_data_out),
        .lifo_full     (lifo_full),
        .lifo_empty    (lifo_empty),
        .trunc         (trunc),
        .busy          (busy)
    );

    // Stack with a registered pop output, reset by the shared rst.
    logic [DATA_W-1:0] mem [DEPTH];
    int                sp;
    assign lifo_full  = (sp == DEPTH);
    assign lifo_empty = (sp == 0);

    always @(posedge clk) begin
        if (rst) begin
            sp            <= 0;
            lifo_data_out <= '0;
        end else if (lifo_w_en && sp < DEPTH) begin
            mem[sp] <= lifo_data_in;
            sp      <= sp + 1;
        end else if (lifo_r_en && sp > 0) begin
            lifo_data_out <= mem[sp-1];
            sp            <= sp - 1;
        end
    end

    // Output collector and protocol watchers, sampled mid-cycle.
    logic [DATA_W:0]   got [$];
    int                overlap_cnt = 0;
    int                trunc_cnt = 0;
    int                sready_viol = 0;
    int                stall_viol = 0;
    int                stall_seen = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W:0]   prev_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (lifo_w_en && lifo_r_en) overlap_cnt <= overlap_cnt + 1;
            if (trunc) trunc_cnt <= trunc_cnt + 1;
            if (s_ready && m_valid) sready_viol <= sready_viol + 1;
            if (prev_stall) begin
                stall_seen <= stall_seen + 1;
                if (!m_valid || {m_last, m_data} !== prev_word) stall_viol <= stall_viol + 1;
            end
            if (m_valid && m_ready) got.push_back({m_last, m_data});
            prev_stall <= m_valid && !m_ready;
            prev_word  <= {m_last, m_data};
        end
    end

    int                errors = 0;
    int                checks = 0;
    int                rmode = 0;
    int                cycles = 0;
    int                rd = 0;
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W-1:0] cur [$];
    logic [3:0]        pat = 4'b1001;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycles++;
        if (rmode == 1) m_ready = 1'($urandom_range(0, 1));
        else if (rmode == 2) m_ready = pat[cycles % 4];
    endtask

    // Reference: a block closes on s_last or when DEPTH words are held; it leaves reversed.
    task automatic model_word(input logic [DATA_W-1:0] d, input logic last);
        cur.push_back(d);
        if (last || cur.size() == DEPTH) begin
            for (int i = cur.size() - 1; i >= 0; i--) exp_q.push_back({(i == 0), cur[i]});
            cur.delete();
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic last, input bit mdl);
        int  n;
        bit  acc;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        if (mdl) model_word(d, last);
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            acc = s_ready;
            cyc();
            n++;
        end
        if (!acc) chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 3000) begin
            cyc();
            n++;
        end
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int k = rd; k < exp_q.size() && k < got.size(); k++)
            chk({tag, "_word"}, 64'(got[k]), 64'(exp_q[k]));
        rd = exp_q.size();
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int base_tr;
        int base_sr;
        int n;
        int len;

        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_trunc", 64'(trunc), 64'd0);
        chk("rst_r_en", 64'(lifo_r_en), 64'd0);
        chk("rst_w_en", 64'(lifo_w_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);

        // Four-word block with a free-running sink.
        m_ready = 1'b1;
        send(32'h11, 1'b0, 1'b1);
        send(32'h22, 1'b0, 1'b1);
        send(32'h33, 1'b0, 1'b1);
        send(32'h44, 1'b1, 1'b1);
        s_valid = 1'b0;
        drain("abcd");

        // Full-depth block with no s_last closes itself.
        base_tr = trunc_cnt;
        base_sr = sready_viol;
        for (int i = 0; i < DEPTH; i++) send(DATA_W'(i), 1'b0, 1'b1);
        s_valid = 1'b0;
        drain("trunc_blk");
        chk("trunc_pulses", 64'(trunc_cnt - base_tr), 64'd1);
        chk("sready_in_drain", 64'(sready_viol - base_sr), 64'd0);

        send(32'hDEADBEEF, 1'b1, 1'b1);
        s_valid = 1'b0;
        drain("single");
        chk("single_s_ready", 64'(s_ready), 64'd1);

        // Stalled sink, pattern 1-0-0-1.
        rmode = 2;
        send(32'd1, 1'b0, 1'b1);
        send(32'd2, 1'b0, 1'b1);
        send(32'd3, 1'b1, 1'b1);
        s_valid = 1'b0;
        drain("stall");
        rmode   = 0;
        m_ready = 1'b1;

        // Reset while the third of five words is being offered.
        for (int i = 1; i <= 5; i++) send(DATA_W'(i), (i == 5), 1'b0);
        s_valid = 1'b0;
        n = 0;
        while (got.size() < rd + 2 && n < 200) begin
            cyc();
            n++;
        end
        m_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd5});
        exp_q.push_back({1'b0, 32'd4});
        n = 0;
        while (!m_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        drain("pre_rst");
        m_ready = 1'b1;
        send(32'd7, 1'b0, 1'b1);
        send(32'd8, 1'b1, 1'b1);
        s_valid = 1'b0;
        drain("post_rst");

        // Back-to-back blocks with s_valid held high across the boundary.
        send(32'd1, 1'b0, 1'b1);
        send(32'd2, 1'b1, 1'b1);
        send(32'd3, 1'b0, 1'b1);
        send(32'd4, 1'b0, 1'b1);
        send(32'd5, 1'b1, 1'b1);
        s_valid = 1'b0;
        drain("b2b");

        // Random blocks, some longer than DEPTH, with a random sink.
        rmode = 1;
        for (int b = 0; b < 8; b++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) send($urandom, (i == len - 1), 1'b1);
            s_valid = 1'b0;
            drain("rand");
        end
        rmode   = 0;
        m_ready = 1'b1;

        chk("no_overlap", 64'(overlap_cnt), 64'd0);
        chk("stall_stable", 64'(stall_viol), 64'd0);
        chk("stall_exercised", 64'(stall_seen > 0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lifo_reverse_ctrl.md
Name: lifo_reverse_ctrl

Overview:
- Initiator-side controller that drives a 32x32 push/pop stack (w_en, r_en, data_in, data_out, full, empty) to reverse framed data blocks.
- Accepts a valid/ready input stream, pushes words until s_last or until the stack is full, then pops every word out on a valid/ready output stream with m_last on the final word.
- Sits between a stream producer and the stack instance. Both blocks share clk and rst.

Parameters:
- DATA_W, 32, data word width; must match stack width.
- DEPTH, 32, stack depth in words; must match stack depth.
- CNT_W, 6, occupancy counter width; must hold 0..DEPTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high. Also drives the stack's rst.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller can accept an input word.
- s_data  in  DATA_W  input word.
- s_last  in  1  input word is the last of its block.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  DATA_W  output word (reversed order).
- m_last  out  1  output word is the last of the block.
- lifo_w_en  out  1  stack push enable.
- lifo_r_en  out  1  stack pop enable.
- lifo_data_in  out  DATA_W  stack push data.
- lifo_data_out  in  DATA_W  stack pop data. Registered in the stack; valid the cycle after lifo_r_en is sampled.
- lifo_full  in  1  stack full.
- lifo_empty  in  1  stack empty.
- trunc  out  1  one-cycle pulse: block closed because DEPTH was reached without s_last.
- busy  out  1  high in any state other than FILL, or when cnt != 0.

Behaviour:
- Reset values: state=FILL, cnt=0, m_valid=0, m_last=0, m_data=0, trunc=0, lifo_w_en=0, lifo_r_en=0.
- Stack interface is never driven with lifo_w_en and lifo_r_en high together.
- Internal cnt tracks occupancy. It is the primary full/empty source. lifo_full and lifo_empty are used only as a safety check:
  - Never push when lifo_full=1.
  - Never pop when lifo_empty=1.
- FILL state:
  - s_ready = (cnt < DEPTH) & !lifo_full.
  - lifo_w_en = s_valid & s_ready; lifo_data_in = s_data (combinational pass-through).
  - On accept: cnt <= cnt+1.
  - If the accepted word has s_last=1, go to POP.
  - If the accept makes cnt reach DEPTH with s_last=0, go to POP and pulse trunc for one cycle. The next input word starts a new block.
- POP state:
  - lifo_r_en=1 for exactly one cycle; cnt <= cnt-1; s_ready=0.
  - Always go to LOAD.
- LOAD state:
  - m_data <= lifo_data_out.
  - m_last <= (cnt==0), where cnt is the value after the decrement.
  - m_valid <= 1; go to OUT.
- OUT state:
  - m_valid=1; m_data and m_last held stable while m_ready=0.
  - On m_ready=1: m_valid <= 0.
  - If m_last=1, clear m_last and go to FILL. Otherwise go to POP.
- Throughput: fill is 1 word/cycle. Drain is 1 word per 3 cycles with m_ready held high.
- Latency: the first output word has m_valid=1 two cycles after the POP cycle.
- Ordering: the output order is the strict reverse of the input order within a block.
- Single-word block: push, then POP, then that word is emitted with m_last=1.
- s_valid may stay high during drain. No word is accepted (s_ready=0) until return to FILL.
- Reset mid-operation: the controller returns to FILL with cnt=0 on the next edge. The stack is reset by the same rst, so no stale data is emitted. A partially emitted block is discarded, and m_valid drops the cycle after rst is sampled.
- Safety: if lifo_empty=1 in POP (count mismatch), suppress lifo_r_en and go to FILL with cnt=0.

Test Plan:
- Block A,B,C,D (0x11,0x22,0x33,0x44; s_last on 0x44), m_ready=1 -> output 0x44,0x33,0x22,0x11; m_last only on 0x11; no lifo_w_en/lifo_r_en overlap.
- 32 words 0..31 without s_last -> trunc pulses once on the 32nd accept; s_ready=0 during drain; output 31..0 with m_last on 0; new block accepted afterwards.
- Single word 0xDEADBEEF with s_last -> 0xDEADBEEF with m_last=1; cnt=0; back to FILL.
- Block 1,2,3 with m_ready toggled 1-0-0-1 -> m_data/m_last stable during stalls; output 3,2,1 with no duplicates or drops.
- rst asserted in OUT after 2 of 5 words emitted -> next cycle m_valid=0, s_ready=1, busy=0; a fresh block 7,8 reverses to 8,7.
- Back-to-back blocks (1,2 last) then (3,4,5 last), s_valid held high -> 2,1 then 5,4,3; m_last on 1 and 3.
